// File: rtl/articolor_pkg.sv
// articolor_pkg
// Shared definitions for the artifact-colour controller:
//   - LUMA_W      : luma sample width
//   - ART_*       : encodings of the 2-bit artifact mode input
//   - state_t     : controller FSM states
//   - luma()      : (r + 2g + b) >> 2 computed in a 10-bit sum
package articolor_pkg;

  localparam int LUMA_W = 8;

  localparam logic [1:0] ART_OFF  = 2'd0;
  localparam logic [1:0] ART_ON   = 2'd1;
  localparam logic [1:0] ART_AUTO = 2'd2;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Luma approximation; the 10-bit sum cannot overflow (max 4*255).
  function automatic logic [LUMA_W-1:0] luma(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [LUMA_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[LUMA_W+1:2];
  endfunction

endpackage

// File: rtl/articolor_detect.sv
// articolor_detect
// Looks for hi-res single-pixel luma patterns (a lone bright or dark pixel
// between two neighbours) in the active video stream.
//
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   ce_pix               : pixel enable; all sampling happens on ce_pix only
//   r_in, g_in, b_in     : 8-bit video samples
//   hbl_in, vbl_in       : blanking (active-high)
//   cand                 : registered candidate flag, updated on every ce_pix;
//                          it describes the sample taken on the previous ce_pix
//
// The window is the current sample (newest) plus the two previous active
// samples of the same line. It is valid once two samples are stored, so the
// first test happens on the third active sample after horizontal blanking.
module articolor_detect
  import articolor_pkg::*;
#(
  parameter int DELTA = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       hbl_in,
  input  logic       vbl_in,
  output logic       cand
);

  // 9-bit compare domain so that l + DELTA never wraps.
  localparam logic [LUMA_W:0] DELTA_EXT = (LUMA_W + 1)'(DELTA);

  logic [LUMA_W-1:0] l0;      // newest sample (current pixel)
  logic [LUMA_W-1:0] l1;      // middle sample (stored)
  logic [LUMA_W-1:0] l2;      // oldest sample (stored)
  logic [1:0]        fill;    // stored active samples since hbl, caps at 2
  logic              active;
  logic              valid;
  logic              is_peak;
  logic              is_valley;
  logic [LUMA_W:0]   e0, e1, e2;

  assign l0     = luma(r_in, g_in, b_in);
  assign active = ~hbl_in & ~vbl_in;
  assign valid  = (fill == 2'd2);

  assign e0 = {1'b0, l0};
  assign e1 = {1'b0, l1};
  assign e2 = {1'b0, l2};

  assign is_peak   = (e1 >= e0 + DELTA_EXT) && (e1 >= e2 + DELTA_EXT);
  assign is_valley = (e1 + DELTA_EXT <= e0) && (e1 + DELTA_EXT <= e2);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      l1   <= '0;
      l2   <= '0;
      fill <= 2'd0;
      cand <= 1'b0;
    end else if (ce_pix) begin
      cand <= active & valid & (is_peak | is_valley);
      if (hbl_in) begin
        // Patterns never straddle a line boundary.
        fill <= 2'd0;
      end else if (active) begin
        l1 <= l0;
        l2 <= l1;
        if (fill != 2'd2) fill <= fill + 2'd1;
      end
    end
  end

endmodule

// File: rtl/articolor_ctrl.sv
// articolor_ctrl
// Frame-synchronous controller for the artifact-colour post-processor.
// User settings are only taken at vertical-sync start so the post-processor
// never changes mid-frame. In auto mode, artifacting is enabled when the
// previous frame held enough single-pixel luma patterns (with hysteresis).
//
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   ce_pix                    : pixel enable
//   mode                      : 0 off, 1 on, 2 auto, 3 off
//   set_req, swap_req         : requested colour set / static phase swap
//   swap_alt                  : invert the swap every frame
//   r_in, g_in, b_in          : video samples
//   hbl_in, vbl_in, vs_in     : blanking and vertical sync, active-high
//   enable_out, colorset_out,
//   colorswap_out             : registered controls to the post-processor
//   frame_hits                : candidate count of the last completed frame
//   fsm_state                 : current controller state (debug/observability)
//
// Frame flow: SYNC (after reset, first partial frame ignored) -> HOLD on the
// first vsync edge; HOLD -> ACTIVE once vsync drops; ACTIVE counts candidates
// until the next vsync edge, then LATCH (one clk) updates the outputs and
// returns to HOLD.
module articolor_ctrl
  import articolor_pkg::*;
#(
  parameter int THRESH = 256,
  parameter int DELTA  = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [1:0]       mode,
  input  logic             set_req,
  input  logic             swap_req,
  input  logic             swap_alt,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  input  logic             hbl_in,
  input  logic             vbl_in,
  input  logic             vs_in,
  output logic             enable_out,
  output logic             colorset_out,
  output logic             colorswap_out,
  output logic [CNT_W-1:0] frame_hits,
  output state_t           fsm_state
);

  localparam logic [31:0] THRESH_HI = 32'(THRESH);
  localparam logic [31:0] THRESH_LO = 32'(THRESH / 2);

  state_t           state;
  state_t           next_state;
  logic             vs_d;
  logic             vs_edge;
  logic             cand;
  logic [CNT_W-1:0] hits;
  logic [31:0]      hits_ext;
  logic             count_en;
  logic             clear_hits;
  logic             latch_en;
  logic             en_next;

  articolor_detect #(
    .DELTA(DELTA)
  ) u_detect (
    .clk    (clk),
    .reset_n(reset_n),
    .ce_pix (ce_pix),
    .r_in   (r_in),
    .g_in   (g_in),
    .b_in   (b_in),
    .hbl_in (hbl_in),
    .vbl_in (vbl_in),
    .cand   (cand)
  );

  assign fsm_state = state;

  // Vertical-sync edge, sampled in the pixel domain.
  always_ff @(posedge clk) begin
    if (!reset_n) vs_d <= 1'b0;
    else if (ce_pix) vs_d <= vs_in;
  end

  assign vs_edge = ce_pix & vs_in & ~vs_d;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= SYNC;
    else state <= next_state;
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      SYNC:    if (vs_edge) next_state = HOLD;
      ACTIVE:  if (vs_edge) next_state = LATCH;
      LATCH:   next_state = HOLD;
      HOLD:    if (ce_pix && !vs_in) next_state = ACTIVE;
      default: next_state = SYNC;
    endcase
  end

  // FSM: outputs. A candidate arriving with the vsync edge belongs to no
  // frame and is dropped.
  always_comb begin
    count_en   = 1'b0;
    clear_hits = 1'b0;
    latch_en   = 1'b0;
    case (state)
      SYNC:    clear_hits = 1'b1;
      ACTIVE:  count_en   = ce_pix & cand & ~vs_edge;
      LATCH: begin
        latch_en   = 1'b1;
        clear_hits = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating per-frame candidate counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hits <= '0;
    end else if (clear_hits) begin
      hits <= '0;
    end else if (count_en && (hits != {CNT_W{1'b1}})) begin
      hits <= hits + 1'b1;
    end
  end

  assign hits_ext = 32'(hits);

  // Enable decision; auto mode holds its value inside the hysteresis band.
  always_comb begin
    en_next = 1'b0;
    case (mode)
      ART_ON:  en_next = 1'b1;
      ART_AUTO: begin
        if (hits_ext >= THRESH_HI)     en_next = 1'b1;
        else if (hits_ext < THRESH_LO) en_next = 1'b0;
        else                           en_next = enable_out;
      end
      ART_OFF: en_next = 1'b0;
      default: en_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_out    <= 1'b0;
      colorset_out  <= 1'b0;
      colorswap_out <= 1'b0;
      frame_hits    <= '0;
    end else if (latch_en) begin
      enable_out    <= en_next;
      colorset_out  <= set_req;
      colorswap_out <= swap_alt ? ~colorswap_out : swap_req;
      frame_hits    <= hits;
    end
  end

endmodule

// File: tb/tb_articolor_ctrl.sv
// tb_articolor_ctrl
// Self-checking bench for articolor_ctrl. Video is generated line by line;
// a reference model counts candidates per line directly from the luma
// values, and at each vertical-sync edge computes the expected latched
// outputs. A second instance with CNT_W=4 checks counter saturation.
module tb_articolor_ctrl;
  import articolor_pkg::*;

  localparam int D      = 10;
  localparam int THR    = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ce_pix;
  logic [1:0]  mode;
  logic        set_req, swap_req, swap_alt;
  logic [7:0]  r_in, g_in, b_in;
  logic        hbl_in, vbl_in, vs_in;

  logic        enable_out, colorset_out, colorswap_out;
  logic [15:0] frame_hits;
  state_t      fsm_state;

  logic        en4, set4, swap4;
  logic [3:0]  hits4;
  state_t      state4;

  articolor_ctrl #(.THRESH(THR), .DELTA(D), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .mode(mode),
    .set_req(set_req), .swap_req(swap_req), .swap_alt(swap_alt),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hbl_in(hbl_in), .vbl_in(vbl_in), .vs_in(vs_in),
    .enable_out(enable_out), .colorset_out(colorset_out),
    .colorswap_out(colorswap_out), .frame_hits(frame_hits),
    .fsm_state(fsm_state)
  );

  articolor_ctrl #(.THRESH(THR), .DELTA(D), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .mode(mode),
    .set_req(set_req), .swap_req(swap_req), .swap_alt(swap_alt),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hbl_in(hbl_in), .vbl_in(vbl_in), .vs_in(vs_in),
    .enable_out(en4), .colorset_out(set4),
    .colorswap_out(swap4), .frame_hits(hits4),
    .fsm_state(state4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // {8'b0, en4, en, set, swap, hits16[15:0], hits4[3:0]}
  logic [31:0] exp_q[$];

  bit m_counting;
  int acc;
  int m_hits;
  bit m_en, m_set, m_swap, m_en4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, want);
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic h, input logic v, input logic s);
    r_in = r; g_in = g; b_in = b;
    hbl_in = h; vbl_in = v; vs_in = s;
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic blank(input logic v, input logic s);
    pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
        8'($urandom_range(0, 255)), 1'b1, v, s);
  endtask

  // kind 0: alternate luma a,b,a,b...; kind 1: random RGB
  task automatic send_line(input int n, input int kind, input int a, input int b);
    int lum[64];
    int rr, gg, bb;
    int cnt;
    repeat (2) blank(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (kind == 0) begin
        rr = (i % 2 == 0) ? a : b;
        gg = rr; bb = rr;
      end else begin
        rr = $urandom_range(0, 255);
        gg = $urandom_range(0, 255);
        bb = $urandom_range(0, 255);
      end
      lum[i] = (rr + 2 * gg + bb) / 4;
      pix(8'(rr), 8'(gg), 8'(bb), 1'b0, 1'b0, 1'b0);
    end
    cnt = 0;
    for (int i = 2; i < n; i++) begin
      if (((lum[i-1] >= lum[i] + D) && (lum[i-1] >= lum[i-2] + D)) ||
          ((lum[i-1] + D <= lum[i]) && (lum[i-1] + D <= lum[i-2])))
        cnt++;
    end
    acc += cnt;
  endtask

  task automatic trail();
    repeat (2) blank(1'b1, 1'b0);
  endtask

  task automatic send_frame(input int lines, input int n, input int kind,
                            input int a, input int b);
    for (int l = 0; l < lines; l++) send_line(n, kind, a, b);
    trail();
  endtask

  task automatic vs_edge();
    logic [2:0]  old3;
    logic [31:0] w;
    bit          latch;
    latch = m_counting;
    old3  = {m_en, m_set, m_swap};
    if (latch) begin
      m_hits = acc;
      if (mode == ART_ON) m_en = 1'b1;
      else if (mode == ART_AUTO) begin
        if (acc >= THR) m_en = 1'b1;
        else if (acc < THR / 2) m_en = 1'b0;
      end else m_en = 1'b0;
      m_en4  = (mode == ART_ON);
      m_set  = set_req;
      m_swap = swap_alt ? !m_swap : swap_req;
    end
    exp_q.push_back({8'd0, m_en4, m_en, m_set, m_swap,
                     16'(sat(m_hits, 65535)), 4'(sat(m_hits, 15))});
    m_counting = 1'b1;
    acc        = 0;

    r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
    hbl_in = 1'b1; vbl_in = 1'b1; vs_in = 1'b1; ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    check("state_after_edge", 32'(fsm_state), latch ? 32'(LATCH) : 32'(HOLD));
    check("outputs_before_latch", 32'({enable_out, colorset_out, colorswap_out}), 32'(old3));
    @(negedge clk);
    w = exp_q.pop_front();
    check("enable_out",    32'(enable_out),    32'(w[22]));
    check("colorset_out",  32'(colorset_out),  32'(w[21]));
    check("colorswap_out", 32'(colorswap_out), 32'(w[20]));
    check("frame_hits",    32'(frame_hits),    32'(w[19:4]));
    check("frame_hits_w4", 32'(hits4),         32'(w[3:0]));
    check("enable_w4",     32'(en4),           32'(w[23]));
    check("set_swap_w4",   32'({set4, swap4}), 32'({w[21], w[20]}));
    check("state_after_latch", 32'(fsm_state), 32'(HOLD));
    repeat (2) blank(1'b1, 1'b1);
    repeat (3) blank(1'b1, 1'b0);
    check("state_active", 32'(fsm_state), 32'(ACTIVE));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_counting = 1'b0; acc = 0; m_hits = 0;
    m_en = 1'b0; m_set = 1'b0; m_swap = 1'b0; m_en4 = 1'b0;
    exp_q.delete();
    check("reset_outputs", 32'({enable_out, colorset_out, colorswap_out}), 32'd0);
    check("reset_frame_hits", 32'(frame_hits), 32'd0);
    check("reset_frame_hits_w4", 32'(hits4), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(SYNC));
  endtask

  task automatic mid_check(input string tag);
    check(tag, 32'({enable_out, colorset_out, colorswap_out, frame_hits}),
          32'({m_en, m_set, m_swap, 16'(sat(m_hits, 65535))}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; ce_pix = 1'b0; mode = ART_OFF;
    set_req = 1'b0; swap_req = 1'b0; swap_alt = 1'b0;
    r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
    hbl_in = 1'b0; vbl_in = 1'b0; vs_in = 1'b0;
    do_reset();

    // Static on: first edge ignored, second latches.
    mode = ART_ON; set_req = 1'b1; swap_req = 1'b0;
    send_frame(2, 12, 1, 0, 0);
    vs_edge();
    send_frame(4, 16, 1, 0, 0);
    vs_edge();

    // Auto mode with hysteresis.
    mode = ART_AUTO;
    send_frame(4, 16, 0, 80, 80);   vs_edge();  // flat: 0 hits, clears
    send_frame(10, 32, 0, 200, 20); vs_edge();  // 300: sets
    send_frame(10, 22, 0, 200, 20); vs_edge();  // 200: holds on
    send_frame(10, 12, 0, 200, 20); vs_edge();  // 100: clears
    send_frame(10, 22, 0, 200, 20); vs_edge();  // 200: holds off

    // Alternating swap, then static swap.
    mode = ART_ON; swap_alt = 1'b1;
    repeat (4) begin send_frame(2, 8, 1, 0, 0); vs_edge(); end
    swap_alt = 1'b0; swap_req = 1'b1;
    repeat (2) begin send_frame(2, 8, 1, 0, 0); vs_edge(); end

    // Mid-frame setting changes take effect only at the next latch.
    set_req = 1'b0;
    send_frame(2, 8, 1, 0, 0); vs_edge();
    send_line(12, 0, 200, 20);
    set_req = 1'b1; mode = ART_OFF;
    send_line(12, 0, 200, 20);
    mid_check("midframe_hold_a");
    mode = ART_AUTO;
    send_line(12, 1, 0, 0);
    mid_check("midframe_hold_b");
    trail();
    vs_edge();

    // Boundaries.
    mode = ART_ON;
    send_frame(10, 2, 0, 200, 20);   vs_edge();  // straddles hbl only
    send_frame(6, 20, 0, 100, 109);  vs_edge();  // DELTA-1 steps
    send_frame(6, 20, 0, 100, 110);  vs_edge();  // exact DELTA steps
    send_frame(6, 20, 0, 250, 245);  vs_edge();  // near top, no wrap
    send_frame(6, 20, 0, 0, 255);    vs_edge();  // full scale

    // Randomized frames.
    repeat (6) begin
      mode     = 2'($urandom_range(0, 3));
      set_req  = 1'($urandom_range(0, 1));
      swap_req = 1'($urandom_range(0, 1));
      swap_alt = 1'($urandom_range(0, 1));
      send_frame($urandom_range(2, 6), $urandom_range(3, 24), $urandom_range(0, 1),
                 $urandom_range(0, 255), $urandom_range(0, 255));
      vs_edge();
    end

    // Reset in the middle of an active frame.
    mode = ART_ON; set_req = 1'b1; swap_alt = 1'b0; swap_req = 1'b1;
    send_frame(3, 10, 0, 200, 20); vs_edge();
    repeat (5) send_line(12, 0, 200, 20);
    blank(1'b0, 1'b0);
    check("state_before_reset", 32'(fsm_state), 32'(ACTIVE));
    do_reset();
    send_line(12, 0, 200, 20);
    trail();
    vs_edge();                                   // nothing latched
    send_frame(4, 12, 0, 30, 90); vs_edge();     // only the new frame

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "timeout");
  end

endmodule
